prog_loader: RTL
================

# prog_loader

Serial program loader that writes a program into the CPU's 16-byte RAM over a UART line. The CPU fetches from that memory; this block writes it. It receives 8N1 bytes, parses a framed, checksummed image and emits one memory write per data byte. It holds the CPU in reset while a load is in progress or has failed, and sits beside the memory between the board RX pin and the RAM write port.

## Interface
- CLKS_PER_BIT, 434, system clocks per UART bit; 50 MHz / 115200. Minimum 4.
- ADDR_WIDTH, 4, RAM address width.
- MEM_DEPTH, 16, maximum image length in bytes. Must satisfy MEM_DEPTH ≤ 2^ADDR_WIDTH.
- TIMEOUT, 1000000, idle clocks allowed between bytes inside a frame before the frame is aborted.
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART line; idles high.
- wr_en  output  1  one-cycle RAM write strobe.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  8  RAM write data.
- cpu_hold  output  1  keeps the CPU in reset while high. OR it into the CPU `rst`.
- done  output  1  one-cycle pulse when an image has loaded with a good checksum.
- error  output  1  sticky flag; set on a protocol, framing or timeout fault.

## Operation
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0. Frame FSM=IDLE, UART receiver=idle, synchroniser flops=1.
- rx passes through a 2-flop synchroniser before any use.
- UART receiver, 8N1, LSB first:
  - A start is a high→low transition of the synchronised rx.
  - Re-sample at CLKS_PER_BIT/2 (floor). If rx is high there, it was a glitch; return to idle with no byte and no error.
  - Sample data bits every CLKS_PER_BIT after the start-bit sample, then sample the stop bit.
  - Stop = 1: the receiver produces a byte-valid pulse for one cycle.
  - Stop = 0: framing error. Set error, force the frame FSM to IDLE, drop the byte, and wait for rx high before the next start.
- Frame format: 0xA5, LEN, LEN data bytes, CSUM. CSUM = 8-bit sum of the data bytes, mod 256.
- Frame FSM:
  - IDLE: a byte of 0xA5 → LEN. It also sets cpu_hold=1, clears error, and clears the address counter and running sum. Any other byte is ignored.
  - LEN: LEN = 0 or LEN > MEM_DEPTH → set error, go to IDLE, keep cpu_hold=1. Otherwise store the count → DATA.
  - DATA: each byte raises wr_en with wr_data = the byte and wr_addr = the counter. The counter then increments and the byte is added to the running sum. After the LEN-th byte → CSUM.
  - CSUM: match → pulse done, cpu_hold=0, go to IDLE. Mismatch → set error, keep cpu_hold=1, go to IDLE.
- A 0xA5 inside DATA is data, not a resync.
- Timeout: in LEN, DATA or CSUM, TIMEOUT clocks with no byte-valid set error and return to IDLE with cpu_hold kept at 1. The idle counter restarts on every byte-valid.
- After any fault, the RAM holds partial contents and the CPU stays held. Only a later successful frame or rst releases the hold.
- Bytes are written as they arrive, not buffered. The address never wraps because of the LEN check.

## Timing
- rx edge to synchronised edge: 2 clocks.
- Byte-valid is asserted the cycle after the stop-bit sample.
- wr_en / wr_addr / wr_data are registered and asserted the cycle after byte-valid. wr_en lasts exactly one cycle and wr_addr/wr_data are stable during it.
- wr_addr and wr_data hold their last values between writes.
- done and the cpu_hold fall occur in the same cycle, one clock after the CSUM byte-valid.
- error rises one clock after the detecting event.
- A reset mid-byte or mid-frame takes effect on the next edge:
  - every output returns to its reset value, including cpu_hold=0;
  - a partially received byte is discarded;
  - the line must return high before the next start is accepted.
- Back-to-back bytes with zero idle time between the stop bit and the next start are supported.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Good load: send A5 03 11 22 33 66 → writes (0,11), (1,22), (2,33) on three single-cycle wr_en pulses. cpu_hold is 1 from the A5 until the CSUM, then done pulses once and cpu_hold=0, error=0.
- Bad checksum: send A5 02 01 02 00 → two writes occur, then error=1, done never pulses and cpu_hold stays 1. A following good frame clears error and releases the hold.
- Length bounds: A5 00 and A5 11 → error=1 and no writes. A5 10 with 16 bytes and the correct sum → writes to addresses 0..15 (no wrap) and done.
- Framing and glitch: a byte with stop=0 → error=1 and FSM in IDLE. A 1-clock low pulse on rx → no byte and no error.
- Timeout and reset: A5 02 AA then silence for TIMEOUT clocks → error=1 and cpu_hold=1. Asserting rst mid-DATA → all outputs return to 0 on the next edge, and a fresh good frame then loads correctly.
- Data containing A5: A5 02 A5 A5 4A → A5 written at addresses 0 and 1, then done.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the CPU's instruction RAM.
//
// Receives 8N1 UART bytes on rx (LSB first), parses frames of the form
//   0xA5, LEN, LEN data bytes, CSUM (8-bit sum of the data bytes)
// and emits one RAM write per data byte as it arrives. cpu_hold keeps
// the CPU in reset from the frame header until a frame completes with a
// good checksum; any fault leaves it held and sets the sticky error flag.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   rx       - asynchronous UART line, idles high
//   wr_en    - one-cycle RAM write strobe
//   wr_addr  - RAM write address (holds between writes)
//   wr_data  - RAM write data (holds between writes)
//   cpu_hold - high while the CPU must stay in reset
//   done     - one-cycle pulse on a successful load
//   error    - sticky protocol/framing/timeout fault flag
module prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 4,
    parameter int MEM_DEPTH    = 16,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);
    localparam logic [8:0]    MAX_LEN   = 9'(MEM_DEPTH);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {F_IDLE, F_LEN, F_DATA, F_CSUM} frame_state_t;

    // ---------------- input synchroniser ----------------
    logic [1:0] sync_reg;
    logic [1:0] settle_reg;
    logic       rx_s;

    assign rx_s = sync_reg[1];

    // settle_reg marks when sync_reg[1] holds a real line sample rather
    // than its reset fill, so a line still low after reset is not taken
    // for a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= 2'b11;
            settle_reg <= 2'b00;
        end else begin
            sync_reg   <= {sync_reg[0], rx};
            settle_reg <= {settle_reg[0], 1'b1};
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t      rx_state_reg, rx_state_next;
    logic [CW-1:0]  clk_cnt_reg, clk_cnt_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic           armed_reg, armed_next;
    logic           byte_valid_reg, byte_valid_next;
    logic           frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg   <= RX_IDLE;
            clk_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            armed_reg      <= 1'b0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            clk_cnt_reg    <= clk_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            armed_reg      <= armed_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // armed_reg: the line has been seen high while idle, so the next low
    // sample is a genuine high-to-low start edge.
    always_comb begin
        rx_state_next   = rx_state_reg;
        clk_cnt_next    = clk_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        armed_next      = armed_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (armed_reg && !rx_s) begin
                    rx_state_next = RX_START;
                    clk_cnt_next  = CW'(1);
                    armed_next    = 1'b0;
                end else if (settle_reg[1] && rx_s) begin
                    armed_next = 1'b1;
                end
            end
            RX_START: begin
                if (clk_cnt_reg == HALF_BIT) begin
                    if (rx_s) begin
                        rx_state_next = RX_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_next = RX_DATA;
                        clk_cnt_next  = CW'(1);
                        bit_cnt_next  = 3'd0;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_reg == BIT_END) begin
                    shift_next   = {rx_s, shift_reg[7:1]};
                    clk_cnt_next = CW'(1);
                    if (bit_cnt_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_reg == BIT_END) begin
                    if (rx_s) begin
                        byte_valid_next = 1'b1;
                        rx_state_next   = RX_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        rx_state_next  = RX_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    frame_state_t          f_state_reg, f_state_next;
    logic [NW-1:0]         len_reg, len_next;
    logic [NW-1:0]         cnt_reg, cnt_next;
    logic [7:0]            sum_reg, sum_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic                  wr_en_reg, wr_en_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]            wr_data_reg, wr_data_next;
    logic                  cpu_hold_reg, cpu_hold_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_state_reg  <= F_IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            timer_reg    <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            cpu_hold_reg <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            f_state_reg  <= f_state_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            sum_reg      <= sum_next;
            timer_reg    <= timer_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            cpu_hold_reg <= cpu_hold_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        f_state_next  = f_state_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        sum_next      = sum_reg;
        timer_next    = timer_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        cpu_hold_next = cpu_hold_reg;
        done_next     = 1'b0;
        error_next    = error_reg;
        if (frame_err_reg) begin
            // A framing error abandons any frame in progress; hold is kept.
            error_next   = 1'b1;
            f_state_next = F_IDLE;
            timer_next   = '0;
        end else if (byte_valid_reg) begin
            timer_next = '0;
            case (f_state_reg)
                F_IDLE: begin
                    if (shift_reg == SYNC_BYTE) begin
                        f_state_next  = F_LEN;
                        cpu_hold_next = 1'b1;
                        error_next    = 1'b0;
                        cnt_next      = '0;
                        sum_next      = '0;
                    end
                end
                F_LEN: begin
                    if (shift_reg == 8'h00 || {1'b0, shift_reg} > MAX_LEN) begin
                        error_next   = 1'b1;
                        f_state_next = F_IDLE;
                    end else begin
                        len_next     = NW'(shift_reg);
                        f_state_next = F_DATA;
                    end
                end
                F_DATA: begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt_reg[ADDR_WIDTH-1:0];
                    wr_data_next = shift_reg;
                    cnt_next     = cnt_reg + NW'(1);
                    sum_next     = sum_reg + shift_reg;
                    if (cnt_reg + NW'(1) == len_reg) begin
                        f_state_next = F_CSUM;
                    end
                end
                F_CSUM: begin
                    if (shift_reg == sum_reg) begin
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b0;
                    end else begin
                        error_next = 1'b1;
                    end
                    f_state_next = F_IDLE;
                end
                default: f_state_next = F_IDLE;
            endcase
        end else if (f_state_reg != F_IDLE) begin
            // Inter-byte silence inside a frame is bounded.
            if (timer_reg == TIMER_END) begin
                error_next   = 1'b1;
                f_state_next = F_IDLE;
                timer_next   = '0;
            end else begin
                timer_next = timer_reg + TW'(1);
            end
        end else begin
            timer_next = '0;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign cpu_hold = cpu_hold_reg;
    assign done     = done_reg;
    assign error    = error_reg;
endmodule
